// File: rtl/alu_urg_pkg.sv
// Shared types and the reference behaviour of the 1-bit URG ALU slice
// used by the BIST sequencer and its comparator.
package alu_urg_pkg;

    typedef enum logic [1:0] {
        AND = 2'b00,
        OR  = 2'b01,
        ADD = 2'b10,
        SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } bist_state_e;

    localparam logic [3:0] LAST_VEC = 4'hF;

    // Returns {r, carry, n}; for SUB carry is the borrow of A-B.
    function automatic logic [2:0] alu_golden(
        input logic    a,
        input logic    b,
        input alu_op_e op
    );
        logic [2:0] g;
        g = 3'b000;
        case (op)
            AND:     g = {a & b, 1'b0, 1'b0};
            OR:      g = {a | b, 1'b0, 1'b0};
            ADD:     g = {a ^ b, a & b, 1'b0};
            SUB:     g = {a ^ b, ~a & b, ~a & b};
            default: g = 3'b000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/alu_urg_cmp.sv
// Registered response checker: compares one sampled ALU response
// against the golden model and keeps failure count, first index and pass.
module alu_urg_cmp
    import alu_urg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       sample_i,
    input  logic       last_i,
    input  logic [3:0] vec_i,
    input  logic       r_i,
    input  logic       carry_i,
    input  logic       n_i,
    output logic [4:0] fail_count_o,
    output logic [3:0] fail_idx_o,
    output logic       pass_o
);

    logic [4:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic       pass_q, pass_d;
    logic [2:0] golden;
    logic       miss;

    assign golden = alu_golden(vec_i[3], vec_i[2], alu_op_e'(vec_i[1:0]));
    assign miss   = sample_i && ({r_i, carry_i, n_i} != golden);

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        pass_d = pass_q;
        if (clr_i) begin
            cnt_d  = 5'd0;
            idx_d  = 4'd0;
            pass_d = 1'b0;
        end else begin
            if (miss) begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd0) begin
                    idx_d = vec_i;
                end
            end
            // Pass must see the verdict of the final vector itself.
            if (sample_i && last_i) begin
                pass_d = (cnt_d == 5'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 5'd0;
            idx_q  <= 4'd0;
            pass_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pass_q <= pass_d;
        end
    end

    assign fail_count_o = cnt_q;
    assign fail_idx_o   = idx_q;
    assign pass_o       = pass_q;

endmodule

// File: rtl/alu_urg_bist.sv
// BIST sequencer for the 1-bit URG ALU slice: sweeps all 16 vectors,
// holds each for SETTLE_CYCLES+1 cycles and samples on the last edge.
module alu_urg_bist
    import alu_urg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] fail_count,
    output logic [3:0] fail_idx,
    output logic       alu_a,
    output logic       alu_b,
    output logic       alucon0,
    output logic       alucon,
    input  logic       alu_r,
    input  logic       alu_carry,
    input  logic       alu_n
);

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    bist_state_e state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        clr, sample, last;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        sample  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = 4'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    clr     = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE) begin
                    sample = 1'b1;
                    cnt_d  = 4'd0;
                    if (vec_q == LAST_VEC) begin
                        // Vector 15 stays on the bus after the sweep.
                        last    = 1'b1;
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    alu_urg_cmp u_cmp (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr),
        .sample_i     (sample),
        .last_i       (last),
        .vec_i        (vec_q),
        .r_i          (alu_r),
        .carry_i      (alu_carry),
        .n_i          (alu_n),
        .fail_count_o (fail_count),
        .fail_idx_o   (fail_idx),
        .pass_o       (pass)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign alu_a   = vec_q[3];
    assign alu_b   = vec_q[2];
    assign alucon  = vec_q[1];
    assign alucon0 = vec_q[0];

endmodule

// File: tb/tb_alu_urg_bist.sv
// Bench for alu_urg_bist: a modelled ALU slice with injectable faults
// drives one SETTLE_CYCLES=1 instance and one SETTLE_CYCLES=0 instance.
module tb_alu_urg_bist;

    localparam int S1   = 1;
    localparam int LAT1 = 16 * (S1 + 1);
    localparam int LAT0 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       st1 = 1'b0, busy1, done1, pass1;
    logic [4:0] fc1;
    logic [3:0] fi1;
    logic       a1, b1, c1, c01, r1, cy1, n1;

    logic       st0 = 1'b0, busy0, done0, pass0;
    logic [4:0] fc0;
    logic [3:0] fi0;
    logic       a0, b0, c0, c00, r0, cy0, n0;

    int         fmode = 0;
    logic [2:0] flipm [16];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Slice behaviour from plain integer arithmetic: {r, carry/borrow, n}.
    function automatic logic [2:0] ref_alu(input logic [3:0] v);
        int a, b, s;
        logic r, cy, n;
        a = int'(v[3]);
        b = int'(v[2]);
        r = 1'b0; cy = 1'b0; n = 1'b0;
        case (v[1:0])
            2'd0: r = ((a * b) == 1);
            2'd1: r = ((a + b) > 0);
            2'd2: begin s = a + b; r = ((s % 2) == 1); cy = (s > 1); end
            default: begin s = a - b; r = (s != 0); cy = (s < 0); n = (s < 0); end
        endcase
        return {r, cy, n};
    endfunction

    function automatic logic [2:0] dut_alu(input logic [3:0] v, input int mode,
                                           input logic [2:0] flip);
        logic [2:0] x;
        x = ref_alu(v);
        case (mode)
            1: x[2] = 1'b0;
            2: x[1] = 1'b0;
            3: x[0] = 1'b1;
            4: x = x ^ flip;
            default: ;
        endcase
        return x;
    endfunction

    logic [3:0] v1, v0;
    logic [2:0] resp1, resp0;
    assign v1 = {a1, b1, c1, c01};
    assign v0 = {a0, b0, c0, c00};
    always_comb resp1 = dut_alu(v1, fmode, flipm[v1]);
    always_comb resp0 = ref_alu(v0);
    assign {r1, cy1, n1} = resp1;
    assign {r0, cy0, n0} = resp0;

    alu_urg_bist #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_count(fc1), .fail_idx(fi1),
        .alu_a(a1), .alu_b(b1), .alucon0(c01), .alucon(c1),
        .alu_r(r1), .alu_carry(cy1), .alu_n(n1)
    );

    alu_urg_bist #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_count(fc0), .fail_idx(fi0),
        .alu_a(a0), .alu_b(b0), .alucon0(c00), .alucon(c0),
        .alu_r(r0), .alu_carry(cy0), .alu_n(n0)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        st1 = 1'b0;
        st0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({busy1, done1, pass1, fc1, fi1, a1, b1, c1, c01} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset1 outputs got %b want 0",
                     {busy1, done1, pass1, fc1, fi1, a1, b1, c1, c01});
        end
        vectors++;
        if ({busy0, done0, pass0, fc0, fi0, a0, b0, c0, c00} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset0 outputs got %b want 0",
                     {busy0, done0, pass0, fc0, fi0, a0, b0, c0, c00});
        end
    endtask

    // One sweep of dut1; start is raised now and accepted on the next edge.
    task automatic run_sweep(input string name, input bit noise, input bit hold);
        int exp_cnt, exp_first, done_at, done_n, ev;
        bit trace_ok, busy_ok;
        exp_cnt = 0;
        exp_first = 0;
        for (int i = 0; i < 16; i++) begin
            if (dut_alu(4'(i), fmode, flipm[i]) != ref_alu(4'(i))) begin
                if (exp_cnt == 0) exp_first = i;
                exp_cnt++;
            end
        end
        trace_ok = 1'b1;
        busy_ok = 1'b1;
        done_at = -1;
        done_n = 0;
        st1 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) st1 = 1'b0;
        for (int c = 0; c <= LAT1 + 1; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (noise && c == 10) st1 = 1'b1;
            if (noise && c == 11) st1 = 1'b0;
            ev = c / (S1 + 1);
            if (ev > 15) ev = 15;
            if (v1 != 4'(ev)) trace_ok = 1'b0;
            if (busy1 != (c < LAT1)) busy_ok = 1'b0;
            if (done1) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
        vectors++;
        if (!trace_ok) begin
            miscompares++;
            $display("FAIL %s vector_order got bad want ok", name);
        end
        vectors++;
        if (!busy_ok) begin
            miscompares++;
            $display("FAIL %s busy_window got bad want ok", name);
        end
        vectors++;
        if (done_at !== LAT1 || done_n !== 1) begin
            miscompares++;
            $display("FAIL %s done got at=%0d n=%0d want at=%0d n=1",
                     name, done_at, done_n, LAT1);
        end
        vectors++;
        if (fc1 !== 5'(exp_cnt)) begin
            miscompares++;
            $display("FAIL %s fail_count got %0d want %0d", name, fc1, exp_cnt);
        end
        vectors++;
        if (fi1 !== 4'(exp_first)) begin
            miscompares++;
            $display("FAIL %s fail_idx got %0d want %0d", name, fi1, exp_first);
        end
        vectors++;
        if (pass1 !== (exp_cnt == 0)) begin
            miscompares++;
            $display("FAIL %s pass got %0b want %0b", name, pass1, exp_cnt == 0);
        end
    endtask

    task automatic test_good();
        fmode = 0;
        run_sweep("good", 1'b0, 1'b0);
    endtask

    task automatic test_stuck();
        fmode = 1;
        run_sweep("r_stuck0", 1'b0, 1'b0);
        vectors++;
        if ({fc1, fi1} !== {5'd8, 4'd5}) begin
            miscompares++;
            $display("FAIL r_stuck0_plan got %0d/%0d want 8/5", fc1, fi1);
        end
        fmode = 2;
        run_sweep("carry_stuck0", 1'b0, 1'b0);
        vectors++;
        if ({fc1, fi1} !== {5'd2, 4'd7}) begin
            miscompares++;
            $display("FAIL carry_stuck0_plan got %0d/%0d want 2/7", fc1, fi1);
        end
        fmode = 3;
        run_sweep("n_stuck1", 1'b0, 1'b0);
        vectors++;
        if ({fc1, fi1} !== {5'd15, 4'd0}) begin
            miscompares++;
            $display("FAIL n_stuck1_plan got %0d/%0d want 15/0", fc1, fi1);
        end
        fmode = 0;
    endtask

    task automatic test_start_ignored();
        fmode = 0;
        run_sweep("start_busy", 1'b1, 1'b0);
    endtask

    task automatic test_rearm();
        fmode = 3;
        run_sweep("rearm", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        vectors++;
        if ({busy1, pass1, fc1, v1} !== {1'b1, 1'b0, 5'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL rearm got busy=%0b pass=%0b fc=%0d v=%0d want 1 0 0 0",
                     busy1, pass1, fc1, v1);
        end
        fmode = 0;
        do_reset();
    endtask

    task automatic test_reset_mid();
        int dn;
        fmode = 1;
        st1 = 1'b1;
        @(posedge clk);
        #1;
        st1 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({busy1, done1, pass1, fc1, fi1, v1} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_mid outputs got %b want 0",
                     {busy1, done1, pass1, fc1, fi1, v1});
        end
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < LAT1 + 8; c++) begin
            @(posedge clk);
            #1;
            if (done1) dn++;
        end
        vectors++;
        if (dn !== 0) begin
            miscompares++;
            $display("FAIL reset_mid done_pulses got %0d want 0", dn);
        end
        fmode = 0;
        run_sweep("after_reset", 1'b0, 1'b0);
    endtask

    task automatic test_settle0();
        int done_at, done_n;
        bit trace_ok, busy_ok;
        done_at = -1;
        done_n = 0;
        trace_ok = 1'b1;
        busy_ok = 1'b1;
        st0 = 1'b1;
        @(posedge clk);
        #1;
        st0 = 1'b0;
        for (int c = 0; c <= LAT0 + 2; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (v0 != 4'((c > 15) ? 15 : c)) trace_ok = 1'b0;
            if (busy0 != (c < LAT0)) busy_ok = 1'b0;
            if (done0) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
        vectors++;
        if (!trace_ok || !busy_ok) begin
            miscompares++;
            $display("FAIL settle0 trace/busy got %0b%0b want 11", trace_ok, busy_ok);
        end
        vectors++;
        if (done_at !== LAT0 || done_n !== 1) begin
            miscompares++;
            $display("FAIL settle0 done got at=%0d n=%0d want at=%0d n=1",
                     done_at, done_n, LAT0);
        end
        vectors++;
        if ({pass0, fc0, fi0} !== {1'b1, 5'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL settle0 result got %0b/%0d/%0d want 1/0/0", pass0, fc0, fi0);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            fmode = $urandom_range(0, 4);
            for (int i = 0; i < 16; i++) begin
                flipm[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            end
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            run_sweep($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), 1'b0);
        end
        fmode = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) flipm[i] = 3'd0;
        test_reset();
        test_good();
        test_stuck();
        test_start_ignored();
        test_rearm();
        test_reset_mid();
        test_settle0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
